// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the state set and beat count
// used by the cache-to-narrow-bus burst adapter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int PMEM_BEATS = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } pmem_burst_state_t;

endpackage

// File: rtl/pmem_burst_adapter_line_assembler.sv
// Line staging for the burst adapter: assembles fill beats into a registered
// line and serves writeback beats from a copy latched when the write is accepted.
module line_assembler
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  lc3b_line    line_in,
    input  logic        slot_we,
    input  logic [2:0]  beat,
    input  lc3b_word    slot_data,
    output lc3b_line    rd_line,
    output lc3b_word    wr_slot
);

    lc3b_line wr_line_reg;
    lc3b_word wr_words [PMEM_BEATS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_line_reg <= '0;
        end else if (load) begin
            wr_line_reg <= line_in;
        end
    end

    // Each fill slot is its own register so a beat only touches its 16 bits.
    generate
        for (genvar gi = 0; gi < PMEM_BEATS; gi++) begin : g_slot
            lc3b_word slot_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    slot_reg <= '0;
                end else if (slot_we && (beat == 3'(gi))) begin
                    slot_reg <= slot_data;
                end
            end

            assign rd_line[gi*16 +: 16] = slot_reg;
            assign wr_words[gi]         = wr_line_reg[gi*16 +: 16];
        end
    endgenerate

    assign wr_slot = wr_words[beat];

endmodule

// File: rtl/pmem_burst_adapter.sv
// Converts whole-line cache requests into 8-beat bursts of 16-bit words on a
// narrow memory bus and returns a one-cycle pmem_resp when the burst ends.
module pmem_burst_adapter
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [15:0] pmem_address,
    input  lc3b_line    pmem_wdata,
    output lc3b_line    pmem_rdata,
    output logic        pmem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output lc3b_word    mem_wdata,
    input  lc3b_word    mem_rdata,
    input  logic        mem_resp
);

    pmem_burst_state_t state_reg, state_next;
    logic [2:0]        beat_reg, beat_next;
    logic [11:0]       line_reg, line_next;
    logic              load_line;
    logic              slot_we;
    lc3b_word          wr_slot;
    logic              unused_offset;

    assign unused_offset = ^pmem_address[3:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            line_reg  <= line_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        line_next  = line_reg;
        load_line  = 1'b0;
        slot_we    = 1'b0;
        pmem_resp  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // Writeback goes first so a victim line leaves before its fill arrives.
                if (pmem_write) begin
                    line_next  = pmem_address[15:4];
                    beat_next  = '0;
                    load_line  = 1'b1;
                    state_next = WR_BURST;
                end else if (pmem_read) begin
                    line_next  = pmem_address[15:4];
                    beat_next  = '0;
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    slot_we   = 1'b1;
                    beat_next = beat_reg + 3'd1;
                    if (beat_reg == 3'd7) begin
                        state_next = DONE;
                    end
                end
            end
            WR_BURST: begin
                mem_write = 1'b1;
                if (mem_resp) begin
                    beat_next = beat_reg + 3'd1;
                    if (beat_reg == 3'd7) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                pmem_resp  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_address = (mem_read || mem_write) ? {line_reg, beat_reg, 1'b0} : 16'h0000;
    assign mem_wdata   = mem_write ? wr_slot : 16'h0000;

    line_assembler u_line (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_line),
        .line_in   (pmem_wdata),
        .slot_we   (slot_we),
        .beat      (beat_reg),
        .slot_data (mem_rdata),
        .rd_line   (pmem_rdata),
        .wr_slot   (wr_slot)
    );

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Scoreboard bench for pmem_burst_adapter: stimulus queues expected beats and
// completions; a negedge monitor compares them as the adapter presents them.
module tb_pmem_burst_adapter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic [127:0] pmem_wdata = '0;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata = '0;
    logic         mem_resp;

    logic         mem_resp_m = 1'b0;
    logic         spurious = 1'b0;
    int           stall = 0;
    int           wcnt = 0;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic [127:0] rdata;
        int           due;
    } cmpl_t;

    beat_t beat_q[$];
    cmpl_t cmpl_q[$];
    beat_t exp_beat;
    cmpl_t exp_cmpl;

    localparam logic [127:0] FILL_LINE = 128'hA007A006A005A004A003A002A001A000;

    assign mem_resp = mem_resp_m | spurious;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_burst_adapter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: `stall` idle cycles before each beat response; fill word = 0xA000 + beat.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (wcnt >= stall) begin
                mem_resp_m = 1'b1;
                mem_rdata  = 16'hA000 + {13'd0, mem_address[3:1]};
                wcnt       = 0;
            end else begin
                mem_resp_m = 1'b0;
                wcnt++;
            end
        end else begin
            mem_resp_m = 1'b0;
            wcnt       = 0;
        end
    end

    // Monitor: compares every presented beat (held steady while stalled) and every completion.
    always @(negedge clk) begin
        #1;
        if (mem_read === 1'b1 || mem_write === 1'b1) begin
            if (beat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got addr %0h with nothing expected", mem_address);
            end else begin
                exp_beat = beat_q[0];
                check("beat_write_strobe", {127'd0, mem_write}, {127'd0, exp_beat.wr});
                check("beat_read_strobe", {127'd0, mem_read}, {127'd0, ~exp_beat.wr});
                check("beat_addr", {112'd0, mem_address}, {112'd0, exp_beat.addr});
                if (exp_beat.wr) check("beat_wdata", {112'd0, mem_wdata}, {112'd0, exp_beat.data});
                if (mem_resp) void'(beat_q.pop_front());
            end
        end
        if (pmem_resp === 1'b1) begin
            if (cmpl_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pmem_resp: got pulse at cycle %0d with none expected", cyc);
            end else begin
                exp_cmpl = cmpl_q.pop_front();
                check("pmem_rdata", pmem_rdata, exp_cmpl.rdata);
                check("pmem_resp_cycle", 128'(cyc), 128'(exp_cmpl.due));
            end
        end
    end

    task automatic wait_resp(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (pmem_resp !== 1'b1 && n < 400);
        if (pmem_resp !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no pmem_resp in %0d cycles, required one", name, n);
        end
    endtask

    task automatic push_read(input logic [15:0] addr);
        for (int i = 0; i < 8; i++) begin
            beat_q.push_back('{1'b0, {addr[15:4], 3'(i), 1'b0}, 16'h0000});
        end
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [15:0] words [8]);
        for (int i = 0; i < 8; i++) begin
            beat_q.push_back('{1'b1, {addr[15:4], 3'(i), 1'b0}, words[i]});
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input int stall_n, input int lat);
        @(negedge clk);
        stall = stall_n;
        push_read(addr);
        cmpl_q.push_back('{FILL_LINE, cyc + 1 + lat});
        pmem_read    = 1'b1;
        pmem_address = addr;
        wait_resp("read");
        pmem_read = 1'b0;
    endtask

    logic [15:0]  wb_words [8];
    logic [15:0]  churn_words [8];
    logic [127:0] churn_line;
    int           n;

    initial begin
        // 1. Reset held two edges
        repeat (2) @(negedge clk);
        #2;
        check("rst_pmem_resp", {127'd0, pmem_resp}, 128'd0);
        check("rst_mem_read", {127'd0, mem_read}, 128'd0);
        check("rst_mem_write", {127'd0, mem_write}, 128'd0);
        check("rst_mem_address", {112'd0, mem_address}, 128'd0);
        check("rst_mem_wdata", {112'd0, mem_wdata}, 128'd0);
        check("rst_pmem_rdata", pmem_rdata, 128'd0);
        reset_n = 1'b1;

        // 2. Zero-wait read fill
        do_read(16'h1236, 0, 8);

        // 3. Writeback; fill line must stay held on pmem_rdata
        wb_words = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        @(negedge clk);
        push_write(16'h40F0, wb_words);
        cmpl_q.push_back('{FILL_LINE, cyc + 9});
        pmem_write   = 1'b1;
        pmem_address = 16'h40F0;
        pmem_wdata   = 128'h0123456789ABCDEF_FEDCBA9876543210;
        wait_resp("write");
        pmem_write = 1'b0;

        // 4. Two idle cycles before every beat response
        do_read(16'h1236, 2, 24);
        stall = 0;

        // 5. Simultaneous request: write first, read one IDLE cycle after DONE
        @(negedge clk);
        push_write(16'h5000, wb_words);
        push_read(16'h6010);
        cmpl_q.push_back('{FILL_LINE, cyc + 9});
        cmpl_q.push_back('{FILL_LINE, cyc + 19});
        pmem_write   = 1'b1;
        pmem_read    = 1'b1;
        pmem_address = 16'h5000;
        wait_resp("simul_write");
        pmem_write   = 1'b0;
        pmem_address = 16'h6010;
        wait_resp("simul_read");
        pmem_read = 1'b0;

        // 6. Spurious mem_resp in IDLE, then a write with churning inputs
        @(negedge clk);
        spurious = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #2;
            check("idle_spur_mem_read", {127'd0, mem_read}, 128'd0);
            check("idle_spur_mem_write", {127'd0, mem_write}, 128'd0);
            check("idle_spur_mem_address", {112'd0, mem_address}, 128'd0);
        end
        spurious = 1'b0;
        @(negedge clk);
        churn_line = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        for (int i = 0; i < 8; i++) churn_words[i] = churn_line[i*16 +: 16];
        push_write(16'h7A3C, churn_words);
        cmpl_q.push_back('{FILL_LINE, cyc + 9});
        pmem_write   = 1'b1;
        pmem_address = 16'h7A3C;
        pmem_wdata   = churn_line;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
            pmem_address = pmem_address + 16'h0130;
            pmem_wdata   = ~pmem_wdata ^ {16{8'(n)}};
        end while (pmem_resp !== 1'b1 && n < 400);
        if (pmem_resp !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL churn_timeout: got no pmem_resp in %0d cycles, required one", n);
        end
        pmem_write = 1'b0;

        // Reset during beat 3 of a read: burst abandoned, no completion
        @(negedge clk);
        push_read(16'h0100);
        pmem_read    = 1'b1;
        pmem_address = 16'h0100;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(mem_read === 1'b1 && mem_address[3:1] == 3'd3) && n < 100);
        check("midrst_reached_beat3", {112'd0, mem_address}, 128'h0106);
        reset_n   = 1'b0;
        pmem_read = 1'b0;
        @(negedge clk);
        #2;
        beat_q.delete();
        check("midrst_pmem_resp", {127'd0, pmem_resp}, 128'd0);
        check("midrst_mem_read", {127'd0, mem_read}, 128'd0);
        check("midrst_mem_address", {112'd0, mem_address}, 128'd0);
        check("midrst_pmem_rdata", pmem_rdata, 128'd0);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        check("final_beats_left", 128'(beat_q.size()), 128'd0);
        check("final_cmpl_left", 128'(cmpl_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish within 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
